// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the parametrised synchronous FIFO family.
//   FIFO_RD_STANDARD / FIFO_RD_FWFT : values for the FWFT read-mode parameter
//   clog2_depth(depth)              : bits needed to hold an occupancy 0..depth
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_RD_STANDARD = 32'sd0;
    localparam int FIFO_RD_FWFT     = 32'sd1;

    // Width of a counter that must represent every value from 0 up to and
    // including depth (hence depth+1 states), never less than one bit.
    function automatic int clog2_depth(input int depth);
        int w;
        w = 32'sd1;
        for (int i = 1; i < 31; i++) begin
            w = ((32'sd1 <<< i) < (depth + 32'sd1)) ? (i + 32'sd1) : w;
        end
        return w;
    endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// -----------------------------------------------------------------------------
// fifo_mem_dp
// Simple dual-port storage array for the FIFO: one synchronous write port and
// one asynchronous read port. Kept separate from the control logic so the
// storage can be remapped to LUT-RAM or EBR without touching pointers/flags.
//
// Ports:
//   i_clk      write clock
//   i_wr_en    write strobe; i_wr_data is stored at i_wr_addr on the clock edge
//   i_wr_addr  write address (0..DEPTH-1)
//   i_wr_data  write data
//   i_rd_addr  read address (0..DEPTH-1)
//   o_rd_data  contents at i_rd_addr (combinational)
// -----------------------------------------------------------------------------
module fifo_mem_dp
    import fifo_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
)(
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    // Storage contents are don't-care after reset, so the array carries no reset.
    logic [WIDTH-1:0] r_mem [DEPTH];

    // Synchronous write port
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
// Parametrised single-clock FIFO with occupancy count, almost-full/empty
// thresholds, sticky overflow/underflow flags, synchronous flush and an
// optional first-word-fall-through read mode.
//
// Ports:
//   i_clk           rising-edge clock for all state
//   i_reset         asynchronous, active-high reset
//   i_flush         synchronous clear of contents and error flags
//   i_push          write request
//   i_data_in       write data, captured when the push is accepted
//   i_pop           read request
//   o_data_out      read data (registered in both read modes)
//   o_full          count == DEPTH
//   o_empty         count == 0
//   o_almost_full   count >= AF_LEVEL
//   o_almost_empty  count <= AE_LEVEL
//   o_count         current occupancy
//   o_overflow      sticky: a push was rejected
//   o_underflow     sticky: a pop was rejected
// -----------------------------------------------------------------------------
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 1,
    parameter int FWFT     = FIFO_RD_STANDARD
)(
    input  logic                               i_clk,
    input  logic                               i_reset,
    input  logic                               i_flush,
    input  logic                               i_push,
    input  logic [WIDTH-1:0]                   i_data_in,
    input  logic                               i_pop,
    output logic [WIDTH-1:0]                   o_data_out,
    output logic                               o_full,
    output logic                               o_empty,
    output logic                               o_almost_full,
    output logic                               o_almost_empty,
    output logic [clog2_depth(DEPTH)-1:0]      o_count,
    output logic                               o_overflow,
    output logic                               o_underflow
);

    localparam int CNT_W = clog2_depth(DEPTH);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // -------------------------------------------------------------------------
    // Elaboration-time parameter legality
    // -------------------------------------------------------------------------
    generate
        if (!((WIDTH >= 1) && (DEPTH >= 2) &&
              (AE_LEVEL > 0) && (AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH) &&
              ((FWFT == FIFO_RD_STANDARD) || (FWFT == FIFO_RD_FWFT)))) begin : g_bad_params
            $error("sync_fifo_param: illegal parameters (need WIDTH>=1, DEPTH>=2, 0<AE_LEVEL<AF_LEVEL<=DEPTH, FWFT in {0,1})");
        end
    endgenerate

    // Pointer increment with explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_W'(DEPTH - 1)) begin
            n = {PTR_W{1'b0}};
        end else begin
            n = p + PTR_W'(1'b1);
        end
        return n;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_data_out;
    logic             r_overflow;
    logic             r_underflow;

    // -------------------------------------------------------------------------
    // Combinational control
    // -------------------------------------------------------------------------
    logic             w_full;
    logic             w_empty;
    logic             w_pop_acc;
    logic             w_push_acc;
    logic             w_mem_we;
    logic [PTR_W-1:0] w_wr_ptr_next;
    logic [PTR_W-1:0] w_rd_ptr_next;
    logic [CNT_W-1:0] w_count_next;
    logic [PTR_W-1:0] w_rd_addr;
    logic [WIDTH-1:0] w_mem_rdata;
    logic [WIDTH-1:0] w_fwft_data;

    // Acceptance decode, next pointers and next occupancy
    always_comb begin
        w_full     = (r_count == CNT_W'(DEPTH));
        w_empty    = (r_count == {CNT_W{1'b0}});
        // A same-cycle push never rescues a pop on empty.
        w_pop_acc  = i_pop & ~w_empty;
        // At full a push still fits when a pop frees a slot on the same edge.
        w_push_acc = i_push & (~w_full | w_pop_acc);
        w_mem_we   = w_push_acc & ~i_flush;

        if (w_push_acc) begin
            w_wr_ptr_next = ptr_inc(r_wr_ptr);
        end else begin
            w_wr_ptr_next = r_wr_ptr;
        end

        if (w_pop_acc) begin
            w_rd_ptr_next = ptr_inc(r_rd_ptr);
        end else begin
            w_rd_ptr_next = r_rd_ptr;
        end

        case ({w_push_acc, w_pop_acc})
            2'b10:   w_count_next = r_count + CNT_W'(1'b1);
            2'b01:   w_count_next = r_count - CNT_W'(1'b1);
            default: w_count_next = r_count;
        endcase
    end

    // Read address and prefetched head word for FWFT mode
    always_comb begin
        // FWFT registers the word that will be at the head after this edge,
        // so the memory is addressed by the next read pointer.
        if (FWFT == FIFO_RD_FWFT) begin
            w_rd_addr = w_rd_ptr_next;
        end else begin
            w_rd_addr = r_rd_ptr;
        end

        // When the next head slot is the one being written on this same edge
        // the array does not hold it yet, so take it straight from the input.
        if (w_count_next == {CNT_W{1'b0}}) begin
            w_fwft_data = {WIDTH{1'b0}};
        end else if (w_push_acc && (w_rd_ptr_next == r_wr_ptr)) begin
            w_fwft_data = i_data_in;
        end else begin
            w_fwft_data = w_mem_rdata;
        end
    end

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    fifo_mem_dp #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .i_clk     (i_clk),
        .i_wr_en   (w_mem_we),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (i_data_in),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_mem_rdata)
    );

    // Pointers, occupancy and sticky error flags
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr    <= {PTR_W{1'b0}};
            r_rd_ptr    <= {PTR_W{1'b0}};
            r_count     <= {CNT_W{1'b0}};
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (i_flush) begin
            r_wr_ptr    <= {PTR_W{1'b0}};
            r_rd_ptr    <= {PTR_W{1'b0}};
            r_count     <= {CNT_W{1'b0}};
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_next;
            r_rd_ptr    <= w_rd_ptr_next;
            r_count     <= w_count_next;
            r_overflow  <= r_overflow  | (i_push & ~w_push_acc);
            r_underflow <= r_underflow | (i_pop  & ~w_pop_acc);
        end
    end

    // Output data register: read-on-pop in standard mode, head word in FWFT mode
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_data_out <= {WIDTH{1'b0}};
        end else if (i_flush) begin
            r_data_out <= {WIDTH{1'b0}};
        end else if (FWFT == FIFO_RD_FWFT) begin
            r_data_out <= w_fwft_data;
        end else if (w_pop_acc) begin
            r_data_out <= w_mem_rdata;
        end else begin
            r_data_out <= r_data_out;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: status flags decode the registered count
    // -------------------------------------------------------------------------
    assign o_data_out     = r_data_out;
    assign o_count        = r_count;
    assign o_full         = w_full;
    assign o_empty        = w_empty;
    assign o_almost_full  = (r_count >= CNT_W'(AF_LEVEL));
    assign o_almost_empty = (r_count <= CNT_W'(AE_LEVEL));
    assign o_overflow     = r_overflow;
    assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_param
// Directed bench for sync_fifo_param with three instances:
//   u_a : DEPTH=4, standard read (AF_LEVEL=2, AE_LEVEL=1)
//   u_b : DEPTH=5, standard read (pointer wrap on a non-power-of-two depth)
//   u_c : DEPTH=4, first-word-fall-through
// -----------------------------------------------------------------------------
module tb_sync_fifo_param;
    import fifo_pkg::*;

    logic clk;
    logic reset;

    int n_checks;
    int n_errors;

    // Instance A
    logic       a_flush, a_push, a_pop;
    logic [7:0] a_din, a_dout;
    logic       a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
    logic [2:0] a_count;

    // Instance B
    logic       b_flush, b_push, b_pop;
    logic [7:0] b_din, b_dout;
    logic       b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
    logic [2:0] b_count;

    // Instance C
    logic       c_flush, c_push, c_pop;
    logic [7:0] c_din, c_dout;
    logic       c_full, c_empty, c_af, c_ae, c_ovf, c_unf;
    logic [2:0] c_count;

    sync_fifo_param #(.WIDTH(8), .DEPTH(4), .FWFT(FIFO_RD_STANDARD)) u_a (
        .i_clk(clk), .i_reset(reset), .i_flush(a_flush),
        .i_push(a_push), .i_data_in(a_din), .i_pop(a_pop),
        .o_data_out(a_dout), .o_full(a_full), .o_empty(a_empty),
        .o_almost_full(a_af), .o_almost_empty(a_ae), .o_count(a_count),
        .o_overflow(a_ovf), .o_underflow(a_unf)
    );

    sync_fifo_param #(.WIDTH(8), .DEPTH(5), .FWFT(FIFO_RD_STANDARD)) u_b (
        .i_clk(clk), .i_reset(reset), .i_flush(b_flush),
        .i_push(b_push), .i_data_in(b_din), .i_pop(b_pop),
        .o_data_out(b_dout), .o_full(b_full), .o_empty(b_empty),
        .o_almost_full(b_af), .o_almost_empty(b_ae), .o_count(b_count),
        .o_overflow(b_ovf), .o_underflow(b_unf)
    );

    sync_fifo_param #(.WIDTH(8), .DEPTH(4), .FWFT(FIFO_RD_FWFT)) u_c (
        .i_clk(clk), .i_reset(reset), .i_flush(c_flush),
        .i_push(c_push), .i_data_in(c_din), .i_pop(c_pop),
        .o_data_out(c_dout), .o_full(c_full), .o_empty(c_empty),
        .o_almost_full(c_af), .o_almost_empty(c_ae), .o_count(c_count),
        .o_overflow(c_ovf), .o_underflow(c_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One clock with the given request on instance A; outputs settle by #1.
    task automatic a_step(input logic push, input logic pop, input logic [7:0] d);
        a_push = push; a_pop = pop; a_din = d;
        @(posedge clk); #1;
        a_push = 1'b0; a_pop = 1'b0;
    endtask

    task automatic a_do_flush();
        a_flush = 1'b1;
        @(posedge clk); #1;
        a_flush = 1'b0;
    endtask

    task automatic b_step(input logic push, input logic pop, input logic [7:0] d);
        b_push = push; b_pop = pop; b_din = d;
        @(posedge clk); #1;
        b_push = 1'b0; b_pop = 1'b0;
    endtask

    task automatic c_step(input logic push, input logic pop, input logic [7:0] d);
        c_push = push; c_pop = pop; c_din = d;
        @(posedge clk); #1;
        c_push = 1'b0; c_pop = 1'b0;
    endtask

    logic [7:0] exp_seq;
    logic [7:0] fill_vals [4];

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        a_flush = 1'b0; a_push = 1'b0; a_pop = 1'b0; a_din = 8'h00;
        b_flush = 1'b0; b_push = 1'b0; b_pop = 1'b0; b_din = 8'h00;
        c_flush = 1'b0; c_push = 1'b0; c_pop = 1'b0; c_din = 8'h00;
        fill_vals[0] = 8'h11; fill_vals[1] = 8'h22;
        fill_vals[2] = 8'h33; fill_vals[3] = 8'h44;

        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 32'(a_count), 32'd0);
        check("rst_empty", 32'(a_empty), 32'd1);
        check("rst_full",  32'(a_full),  32'd0);
        check("rst_ae",    32'(a_ae),    32'd1);
        check("rst_af",    32'(a_af),    32'd0);
        check("rst_dout",  32'(a_dout),  32'h0);
        check("rst_ovf",   32'(a_ovf),   32'd0);
        check("rst_unf",   32'(a_unf),   32'd0);
        reset = 1'b0;
        #4;

        // ---------------- A: fill to full ----------------
        a_step(1'b1, 1'b0, 8'h11);
        check("fill1_count", 32'(a_count), 32'd1);
        check("fill1_af",    32'(a_af),    32'd0);
        check("fill1_ae",    32'(a_ae),    32'd1);
        check("fill1_empty", 32'(a_empty), 32'd0);
        a_step(1'b1, 1'b0, 8'h22);
        check("fill2_af",    32'(a_af),    32'd1);
        check("fill2_ae",    32'(a_ae),    32'd0);
        a_step(1'b1, 1'b0, 8'h33);
        check("fill3_full",  32'(a_full),  32'd0);
        a_step(1'b1, 1'b0, 8'h44);
        check("fill4_full",  32'(a_full),  32'd1);
        check("fill4_count", 32'(a_count), 32'd4);

        // Push while full is rejected
        a_step(1'b1, 1'b0, 8'h55);
        check("ovf_flag",  32'(a_ovf),   32'd1);
        check("ovf_count", 32'(a_count), 32'd4);
        check("ovf_unf",   32'(a_unf),   32'd0);

        // Drain: each word visible one cycle after its pop
        for (int i = 0; i < 4; i++) begin
            a_step(1'b0, 1'b1, 8'h00);
            check($sformatf("drain%0d_dout", i), 32'(a_dout), 32'(fill_vals[i]));
        end
        check("drain_empty", 32'(a_empty), 32'd1);

        // Pop while empty is rejected; data_out holds
        a_step(1'b0, 1'b1, 8'h00);
        check("unf_flag",  32'(a_unf),   32'd1);
        check("unf_dout",  32'(a_dout),  32'h44);
        check("unf_count", 32'(a_count), 32'd0);
        check("unf_ovf",   32'(a_ovf),   32'd1);

        // Flush clears flags and data, ignoring same-cycle requests
        a_push = 1'b1; a_pop = 1'b1; a_din = 8'h99;
        a_do_flush();
        a_push = 1'b0; a_pop = 1'b0;
        check("flush_ovf",   32'(a_ovf),   32'd0);
        check("flush_unf",   32'(a_unf),   32'd0);
        check("flush_count", 32'(a_count), 32'd0);
        check("flush_dout",  32'(a_dout),  32'h0);

        // Simultaneous push+pop at full
        for (int i = 0; i < 4; i++) begin
            a_step(1'b1, 1'b0, fill_vals[i]);
        end
        a_step(1'b1, 1'b1, 8'hAA);
        check("fullpp_count", 32'(a_count), 32'd4);
        check("fullpp_dout",  32'(a_dout),  32'h11);
        check("fullpp_ovf",   32'(a_ovf),   32'd0);
        a_step(1'b0, 1'b1, 8'h00);
        check("fullpp_rd1", 32'(a_dout), 32'h22);
        a_step(1'b0, 1'b1, 8'h00);
        check("fullpp_rd2", 32'(a_dout), 32'h33);
        a_step(1'b0, 1'b1, 8'h00);
        check("fullpp_rd3", 32'(a_dout), 32'h44);
        a_step(1'b0, 1'b1, 8'h00);
        check("fullpp_rd4", 32'(a_dout), 32'hAA);
        check("fullpp_empty", 32'(a_empty), 32'd1);

        // Simultaneous push+pop at empty: pop rejected, push kept
        a_step(1'b1, 1'b1, 8'h5A);
        check("emptypp_count", 32'(a_count), 32'd1);
        check("emptypp_unf",   32'(a_unf),   32'd1);
        check("emptypp_dout",  32'(a_dout),  32'hAA);
        a_step(1'b0, 1'b1, 8'h00);
        check("emptypp_rd", 32'(a_dout), 32'h5A);

        // ---------------- B: wrap on DEPTH=5 ----------------
        exp_seq = 8'd1;
        for (int i = 0; i < 12; i++) begin
            b_step(1'b1, (i >= 3), 8'(i + 1));
            if (i >= 3) begin
                check($sformatf("wrap_rd%0d", i), 32'(b_dout), 32'(exp_seq));
                exp_seq = exp_seq + 8'd1;
            end
        end
        check("wrap_count", 32'(b_count), 32'd3);
        check("wrap_af",    32'(b_af),    32'd1);
        check("wrap_ae",    32'(b_ae),    32'd0);
        check("wrap_full",  32'(b_full),  32'd0);
        for (int i = 0; i < 3; i++) begin
            b_step(1'b0, 1'b1, 8'h00);
            check($sformatf("wrap_drain%0d", i), 32'(b_dout), 32'(exp_seq));
            exp_seq = exp_seq + 8'd1;
        end
        check("wrap_empty", 32'(b_empty), 32'd1);
        check("wrap_ovf",   32'(b_ovf),   32'd0);
        check("wrap_unf",   32'(b_unf),   32'd0);

        // ---------------- C: FWFT ----------------
        check("fwft_rst_dout", 32'(c_dout), 32'h0);
        c_step(1'b1, 1'b0, 8'h7E);
        check("fwft_push_dout",  32'(c_dout),  32'h7E);
        check("fwft_push_count", 32'(c_count), 32'd1);
        c_step(1'b0, 1'b0, 8'h00);
        check("fwft_idle_dout", 32'(c_dout), 32'h7E);
        c_step(1'b0, 1'b1, 8'h00);
        check("fwft_pop_empty", 32'(c_empty), 32'd1);
        check("fwft_pop_dout",  32'(c_dout),  32'h0);
        c_step(1'b1, 1'b0, 8'h01);
        check("fwft_p1_dout", 32'(c_dout), 32'h01);
        c_step(1'b1, 1'b1, 8'h02);
        check("fwft_pp_dout",  32'(c_dout),  32'h02);
        check("fwft_pp_count", 32'(c_count), 32'd1);
        c_step(1'b0, 1'b1, 8'h00);
        check("fwft_end_dout",  32'(c_dout),  32'h0);
        check("fwft_end_empty", 32'(c_empty), 32'd1);
        check("fwft_end_full",  32'(c_full),  32'd0);
        check("fwft_end_af",    32'(c_af),    32'd0);
        check("fwft_end_ae",    32'(c_ae),    32'd1);
        check("fwft_end_ovf",   32'(c_ovf),   32'd0);
        check("fwft_end_unf",   32'(c_unf),   32'd0);

        // ---------------- A: asynchronous reset mid-stream ----------------
        a_step(1'b0, 1'b1, 8'h00);
        a_step(1'b1, 1'b0, 8'h01);
        a_step(1'b1, 1'b0, 8'h02);
        a_step(1'b1, 1'b0, 8'h03);
        check("pre_rst_count", 32'(a_count), 32'd3);
        check("pre_rst_unf",   32'(a_unf),   32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_count", 32'(a_count), 32'd0);
        check("arst_empty", 32'(a_empty), 32'd1);
        check("arst_dout",  32'(a_dout),  32'h0);
        check("arst_ovf",   32'(a_ovf),   32'd0);
        check("arst_unf",   32'(a_unf),   32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
